// File: rtl/sgnl_debounce_if.sv
// sgnl_debounce_if: signal bundle between a raw input source and the debouncer.
// The master drives the raw level and clear; the slave returns the clean level.
interface sgnl_debounce_if #(
   parameter int p_glitch_width = 8
);
   logic                      i_sgnl;
   logic                      i_glitch_clr;
   logic                      o_sgnl;
   logic                      o_rise;
   logic                      o_fall;
   logic [p_glitch_width-1:0] o_glitch_cnt;

   modport master (
      output i_sgnl,
      output i_glitch_clr,
      input  o_sgnl,
      input  o_rise,
      input  o_fall,
      input  o_glitch_cnt
   );

   modport slave (
      input  i_sgnl,
      input  i_glitch_clr,
      output o_sgnl,
      output o_rise,
      output o_fall,
      output o_glitch_cnt
   );
endinterface

// File: rtl/sgnl_debounce.sv
// sgnl_debounce: synchronises a raw bouncing input and qualifies level changes.
// Emits a clean level, edge pulses and a saturating rejected-glitch count.
module sgnl_debounce #(
   parameter int p_sync_stages     = 2,
   parameter int p_debounce_cycles = 16,
   parameter int p_glitch_width    = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   sgnl_debounce_if.slave   bus
);
   localparam int CW = $clog2(p_debounce_cycles);
   localparam logic [CW-1:0] CNT_LAST =
      CW'(p_debounce_cycles - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [1:0] {
      S_LOW      = 2'd0,
      S_RISE_CHK = 2'd1,
      S_HIGH     = 2'd2,
      S_FALL_CHK = 2'd3
   } state_t;

   logic [p_sync_stages-1:0]  sync_q;
   logic                      syn;
   state_t                    state;
   logic [CW-1:0]             cnt;
   logic                      sgnl_q;
   logic                      rise_q;
   logic                      fall_q;
   logic                      glitch_evt;
   logic [p_glitch_width-1:0] glitch_cnt;

   assign syn = sync_q[p_sync_stages-1];

   // A candidate level that reverts before qualifying is a glitch.
   assign glitch_evt = ((state == S_RISE_CHK) && !syn) ||
                       ((state == S_FALL_CHK) &&  syn);

   // Shift the raw input through the synchroniser chain.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[p_sync_stages-2:0], bus.i_sgnl};
      end
   end

   // Qualify level changes; outputs are registered alongside the state.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state  <= S_LOW;
         cnt    <= '0;
         sgnl_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         unique case (state)
            S_LOW: begin
               if (syn) begin
                  state <= S_RISE_CHK;
                  cnt   <= CNT_ONE;
               end
            end
            S_RISE_CHK: begin
               if (!syn) begin
                  state <= S_LOW;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state  <= S_HIGH;
                  cnt    <= '0;
                  sgnl_q <= 1'b1;
                  rise_q <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_HIGH: begin
               if (!syn) begin
                  state <= S_FALL_CHK;
                  cnt   <= CNT_ONE;
               end
            end
            S_FALL_CHK: begin
               if (syn) begin
                  state <= S_HIGH;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state  <= S_LOW;
                  cnt    <= '0;
                  sgnl_q <= 1'b0;
                  fall_q <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= S_LOW;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Count rejected glitches, saturating; clear wins over a new event.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         glitch_cnt <= '0;
      end else if (bus.i_glitch_clr) begin
         glitch_cnt <= '0;
      end else if (glitch_evt && (glitch_cnt != '1)) begin
         glitch_cnt <= glitch_cnt + 1'b1;
      end
   end

   assign bus.o_sgnl       = sgnl_q;
   assign bus.o_rise       = rise_q;
   assign bus.o_fall       = fall_q;
   assign bus.o_glitch_cnt = glitch_cnt;
endmodule

// File: tb/tb_sgnl_debounce.sv
// tb_sgnl_debounce: directed stimulus with a cycle-stamped scoreboard.
// Stimulus queues expected output tuples; a negedge monitor checks them.
module tb_sgnl_debounce;
   localparam int PS = 2;
   localparam int PD = 16;
   localparam int GW = 2;

   logic i_clk = 1'b0;
   logic i_rst = 1'b0;
   int   cyc   = 0;
   int   vecs  = 0;
   int   miss  = 0;

   sgnl_debounce_if #(.p_glitch_width(GW)) bus ();

   sgnl_debounce #(
      .p_sync_stages    (PS),
      .p_debounce_cycles(PD),
      .p_glitch_width   (GW)
   ) dut (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .bus  (bus)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc <= cyc + 1;

   typedef struct {
      int            at;
      logic          s;
      logic          r;
      logic          f;
      logic [GW-1:0] g;
      string         tag;
   } exp_t;

   exp_t q[$];

   function automatic void push(int at, logic s, logic r,
                                logic f, int g, string tag);
      exp_t e;
      int   i;
      e.at  = at;
      e.s   = s;
      e.r   = r;
      e.f   = f;
      e.g   = GW'(g);
      e.tag = tag;
      i = q.size();
      while (i > 0 && q[i-1].at > at) i--;
      q.insert(i, e);
   endfunction

   task automatic wait_cyc(int n);
      repeat (n) @(negedge i_clk);
   endtask

   exp_t m_e;
   logic m_hit;

   // Compare every expectation stamped with the current cycle.
   always @(negedge i_clk) begin
      m_hit = 1'b0;
      while (q.size() != 0 && q[0].at < cyc) begin
         m_e = q.pop_front();
         vecs++;
         miss++;
         $display("FAIL %s @%0d: check skipped, now cycle %0d",
                  m_e.tag, m_e.at, cyc);
      end
      while (q.size() != 0 && q[0].at == cyc) begin
         m_e = q.pop_front();
         vecs++;
         if (m_e.r || m_e.f) m_hit = 1'b1;
         if ({bus.o_sgnl, bus.o_rise, bus.o_fall, bus.o_glitch_cnt} !==
             {m_e.s, m_e.r, m_e.f, m_e.g}) begin
            miss++;
            $display("FAIL %s @%0d: got s=%b r=%b f=%b g=%0d, want s=%b r=%b f=%b g=%0d",
                     m_e.tag, cyc, bus.o_sgnl, bus.o_rise, bus.o_fall,
                     bus.o_glitch_cnt, m_e.s, m_e.r, m_e.f, m_e.g);
         end
      end
      if ((bus.o_rise || bus.o_fall) && !m_hit) begin
         vecs++;
         miss++;
         $display("FAIL stray_pulse @%0d: got r=%b f=%b, want r=0 f=0",
                  cyc, bus.o_rise, bus.o_fall);
      end
   end

   int c;
   int d;
   int r;
   int sat_exp [5] = '{1, 2, 3, 3, 3};

   initial begin
      bus.i_sgnl       = 1'b0;
      bus.i_glitch_clr = 1'b0;
      push(1, 0, 0, 0, 0, "rst_state");
      push(2, 0, 0, 0, 0, "rst_state");
      wait_cyc(3);
      i_rst = 1'b1;

      // idle low for 100 cycles
      c = cyc;
      for (int j = 1; j <= 100; j++) push(c + j, 0, 0, 0, 0, "idle");
      wait_cyc(100);

      // clean rising step then clean falling step
      c = cyc;
      bus.i_sgnl = 1'b1;
      push(c + 17, 0, 0, 0, 0, "rise_early");
      push(c + 18, 1, 1, 0, 0, "rise_lat");
      push(c + 19, 1, 0, 0, 0, "rise_after");
      wait_cyc(30);
      c = cyc;
      bus.i_sgnl = 1'b0;
      push(c + 17, 1, 0, 0, 0, "fall_early");
      push(c + 18, 0, 0, 1, 0, "fall_lat");
      push(c + 19, 0, 0, 0, 0, "fall_after");
      wait_cyc(30);

      // 15-sample pulse rejected
      c = cyc;
      bus.i_sgnl = 1'b1;
      push(c + 17, 0, 0, 0, 0, "g15_pre");
      push(c + 18, 0, 0, 0, 1, "g15_reject");
      push(c + 30, 0, 0, 0, 1, "g15_hold");
      wait_cyc(15);
      bus.i_sgnl = 1'b0;
      wait_cyc(20);

      // 16-sample pulse accepted, then qualified fall
      c = cyc;
      bus.i_sgnl = 1'b1;
      push(c + 17, 0, 0, 0, 1, "p16_early");
      push(c + 18, 1, 1, 0, 1, "p16_rise");
      wait_cyc(16);
      d = cyc;
      bus.i_sgnl = 1'b0;
      push(d + 17, 1, 0, 0, 1, "p16_fall_early");
      push(d + 18, 0, 0, 1, 1, "p16_fall");
      push(d + 19, 0, 0, 0, 1, "p16_fall_after");
      wait_cyc(30);

      // clear, then saturate the 2-bit glitch counter
      c = cyc;
      bus.i_glitch_clr = 1'b1;
      push(c + 1, 0, 0, 0, 0, "clr");
      wait_cyc(1);
      bus.i_glitch_clr = 1'b0;
      wait_cyc(2);
      for (int k = 0; k < 5; k++) begin
         c = cyc;
         bus.i_sgnl = 1'b1;
         push(c + 6, 0, 0, 0, sat_exp[k], "sat");
         wait_cyc(3);
         bus.i_sgnl = 1'b0;
         wait_cyc(5);
      end

      // clear coincident with a glitch event
      c = cyc;
      bus.i_sgnl = 1'b1;
      push(c + 5, 0, 0, 0, 3, "pre_clr");
      push(c + 6, 0, 0, 0, 0, "clr_prio");
      wait_cyc(3);
      bus.i_sgnl = 1'b0;
      wait_cyc(2);
      bus.i_glitch_clr = 1'b1;
      wait_cyc(1);
      bus.i_glitch_clr = 1'b0;
      wait_cyc(5);

      // one glitch so reset has something to clear
      c = cyc;
      bus.i_sgnl = 1'b1;
      push(c + 6, 0, 0, 0, 1, "pre_rst_glitch");
      wait_cyc(3);
      bus.i_sgnl = 1'b0;
      wait_cyc(8);

      // reset mid-qualification with input held high
      c = cyc;
      r = c + 15;
      bus.i_sgnl = 1'b1;
      push(c + 12, 0, 0, 0, 1, "pre_rst");
      push(c + 13, 0, 0, 0, 0, "in_rst");
      push(c + 14, 0, 0, 0, 0, "in_rst");
      push(r + 17, 0, 0, 0, 0, "rel_early");
      push(r + 18, 1, 1, 0, 0, "rel_rise");
      push(r + 19, 1, 0, 0, 0, "rel_after");
      wait_cyc(12);
      #2 i_rst = 1'b0;
      wait_cyc(3);
      i_rst = 1'b1;
      wait_cyc(30);

      // short low bounce while high
      c = cyc;
      bus.i_sgnl = 1'b0;
      push(c + 5, 1, 0, 0, 0, "bounce_mid");
      push(c + 6, 1, 0, 0, 1, "bounce_rej");
      push(c + 25, 1, 0, 0, 1, "bounce_hold");
      wait_cyc(3);
      bus.i_sgnl = 1'b1;
      wait_cyc(30);

      while (q.size() != 0) begin
         m_e = q.pop_front();
         vecs++;
         miss++;
         $display("FAIL %s @%0d: check never reached", m_e.tag, m_e.at);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end
endmodule
